vigenere_deciph: RTL

VIGENERE_DECIPH -- requirements
Module: vigenere_deciph

---
 rtl/vigenere_pkg.sv | 41 ++++
 rtl/vigenere_unshift.sv | 36 +++
 rtl/vigenere_deciph.sv | 75 +++++++
 3 files changed

// File: rtl/vigenere_pkg.sv
// Shared Vigenere definitions: ASCII bounds, alphabet size, FSM states, key-to-shift mapping.
// No latency; constants and pure functions only.
// No backpressure; used by both the encoder and the decoder.
package vigenere_pkg;

    localparam logic [7:0] ASCII_LA  = 8'h61;  // 'a'
    localparam logic [7:0] ASCII_LZ  = 8'h7a;  // 'z'
    localparam logic [7:0] ASCII_UA  = 8'h41;  // 'A'
    localparam logic [7:0] ASCII_UZ  = 8'h5a;  // 'Z'
    localparam int         ALPHA_LEN = 26;

    typedef enum logic {
        NOKEY = 1'b0,
        RUN   = 1'b1
    } state_t;

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= ASCII_LA) && (c <= ASCII_LZ);
    endfunction

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= ASCII_UA) && (c <= ASCII_UZ);
    endfunction

    function automatic logic is_alpha(input logic [7:0] c);
        return is_lower(c) || is_upper(c);
    endfunction

    // Letters of either case map to 0..25; anything else is a zero shift.
    function automatic logic [4:0] key_to_shift(input logic [7:0] k);
        logic [4:0] s;
        s = 5'd0;
        if (is_lower(k)) begin
            s = 5'(k - ASCII_LA);
        end else if (is_upper(k)) begin
            s = 5'(k - ASCII_UA);
        end
        return s;
    endfunction

endpackage

// File: rtl/vigenere_unshift.sv
// Rotates a letter backwards by shift within its own case; non-letters pass through.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the result is used.
module vigenere_unshift
    import vigenere_pkg::*;
(
    input  logic [7:0] src,
    input  logic [4:0] shift,
    output logic [7:0] dst
);

    localparam logic [6:0] A26 = 7'(ALPHA_LEN);

    logic       lower;
    logic       upper;
    logic [7:0] base;
    logic [4:0] off;
    logic [6:0] sum;

    // Offset within the alphabet, add 26 before subtracting so the result never goes negative, then fold once.
    always_comb begin
        lower = is_lower(src);
        upper = is_upper(src);
        base  = lower ? ASCII_LA : ASCII_UA;
        off   = 5'(src - base);
        sum   = {2'b00, off} + A26 - {2'b00, shift};
        if (sum >= A26) begin
            sum = sum - A26;
        end
        dst = src;
        if (lower || upper) begin
            dst = base + {3'b000, sum[4:0]};
        end
    end

endmodule

// File: rtl/vigenere_deciph.sv
// Vigenere decipher: key table load, NOKEY/RUN control, per-letter key index, registered plaintext.
// Latency 1 cycle from accepted ct to pt/pt_valid.
// ct_ready is low until the key is committed, then stays high; the block never stalls in RUN.
module vigenere_deciph
    import vigenere_pkg::*;
#(
    parameter int KEY_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 ct,
    input  logic                       ct_valid,
    output logic                       ct_ready,
    input  logic                       key_we,
    input  logic [$clog2(KEY_LEN)-1:0] key_addr,
    input  logic [7:0]                 key_data,
    input  logic                       key_commit,
    output logic [7:0]                 pt,
    output logic                       pt_valid
);

    localparam int IW = $clog2(KEY_LEN);
    localparam logic [IW-1:0] LAST_IDX = IW'(KEY_LEN - 1);

    state_t        state;
    logic [IW-1:0] idx;
    logic [4:0]    shifts [KEY_LEN];
    logic [4:0]    cur_shift;
    logic [7:0]    dec;
    logic          accept;

    assign ct_ready  = (state == RUN);
    assign accept    = ct_valid && ct_ready;
    assign cur_shift = shifts[idx];

    vigenere_unshift u_unshift (
        .src   (ct),
        .shift (cur_shift),
        .dst   (dec)
    );

    // Control, key table, key index and output register; decode reads the table before any same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= NOKEY;
            idx      <= '0;
            pt       <= 8'h00;
            pt_valid <= 1'b0;
            for (int i = 0; i < KEY_LEN; i++) begin
                shifts[i] <= 5'd0;
            end
        end else begin
            pt_valid <= accept;
            if (accept) begin
                pt <= dec;
            end

            if (key_we && (int'(key_addr) < KEY_LEN)) begin
                shifts[key_addr] <= key_to_shift(key_data);
            end

            if (key_commit && (state == NOKEY)) begin
                state <= RUN;
            end

            // Any key activity restarts the key from slot 0, overriding a same-edge letter advance.
            if (key_we || key_commit) begin
                idx <= '0;
            end else if (accept && is_alpha(ct)) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule
